wbc_return_mux: RTL and testbench

- Slave-side counterpart of the bus address decoder: one Wishbone classic master fans out to NS slaves.
- Takes the decoder's slave index, latches it at cycle start, and routes cyc/stb to that one slave.
- Muxes ack/err/data from that slave back to the master.
- Answers unmapped addresses and hung slaves with a bus error, so the CPU never deadlocks.

---
 rtl/wbc_pkg.sv | 23 ++
 rtl/wbc_return_mux_if.sv | 44 ++++
 rtl/wbc_timeout.sv | 41 ++++
 rtl/wbc_return_mux.sv | 123 ++++++++++++
 tb/tb_wbc_return_mux.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wbc_pkg.sv
// Shared definitions for the Wishbone classic return mux.
//   wbc_state_t : cycle tracker states (IDLE / BUSY / FAULT)
//   WBC_NOHIT   : all-ones decoder index meaning "no slave decoded"
//   wbc_clog2   : ceiling log2 used to size counters and index fields
package wbc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    FAULT = 2'd2
  } wbc_state_t;

  // Wide all-ones value; users slice it down to their own index width.
  localparam logic [31:0] WBC_NOHIT = 32'hFFFF_FFFF;

  function automatic int wbc_clog2(input int value);
    int r;
    r = 0;
    while ((64'd1 << r) < 64'(value)) r++;
    return r;
  endfunction

endpackage

// File: rtl/wbc_return_mux_if.sv
// Bus bundle between one Wishbone classic master, the return mux, and NS slaves.
//   m_*_i / m_*_o : master side (names seen from the mux)
//   s_*_o / s_*_i : slave side; s_dat_i packs slave k at [k*DATAWIDTH +: DATAWIDTH]
// Modports:
//   slave  : used by the mux itself (it is the slave of the master)
//   master : used by the environment that owns both the master and the slaves
interface wbc_return_mux_if #(
  parameter int NS        = 8,
  parameter int ADDRWIDTH = 32,
  parameter int DATAWIDTH = 32
);
  logic                    m_cyc_i;
  logic                    m_stb_i;
  logic                    m_we_i;
  logic [DATAWIDTH/8-1:0]  m_sel_i;
  logic [ADDRWIDTH-1:0]    m_adr_i;
  logic [DATAWIDTH-1:0]    m_dat_i;
  logic [DATAWIDTH-1:0]    m_dat_o;
  logic                    m_ack_o;
  logic                    m_err_o;
  logic [NS-1:0]           s_cyc_o;
  logic [NS-1:0]           s_stb_o;
  logic                    s_we_o;
  logic [DATAWIDTH/8-1:0]  s_sel_o;
  logic [ADDRWIDTH-1:0]    s_adr_o;
  logic [DATAWIDTH-1:0]    s_dat_o;
  logic [NS*DATAWIDTH-1:0] s_dat_i;
  logic [NS-1:0]           s_ack_i;
  logic [NS-1:0]           s_err_i;

  modport slave (
    input  m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_adr_i, m_dat_i,
    output m_dat_o, m_ack_o, m_err_o,
    output s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o,
    input  s_dat_i, s_ack_i, s_err_i
  );

  modport master (
    output m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_adr_i, m_dat_i,
    input  m_dat_o, m_ack_o, m_err_o,
    input  s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o,
    output s_dat_i, s_ack_i, s_err_i
  );
endinterface

// File: rtl/wbc_timeout.sv
// Strobe watchdog for the return mux.
//   clk, rst : clock, asynchronous active-high reset
//   en       : a strobe is waiting for a response this cycle
//   clear    : restart counting (response seen, strobe idle, or not busy)
//   expired  : counter has reached TIMEOUT-1; always 0 when TIMEOUT == 0
module wbc_timeout
  import wbc_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clear,
  output logic expired
);
  localparam int CW_RAW = wbc_clog2(TIMEOUT + 1);
  localparam int CW     = (CW_RAW < 1) ? 1 : CW_RAW;
  localparam int TLAST  = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

  logic [CW-1:0] count_reg;

  // Saturates at all-ones so a disabled watchdog can never wrap into a match.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (en && (count_reg != {CW{1'b1}})) begin
      count_reg <= count_reg + CW'(1);
    end
  end

  generate
    if (TIMEOUT == 0) begin : g_off
      assign expired = 1'b0;
    end else begin : g_on
      assign expired = (count_reg == CW'(TLAST));
    end
  endgenerate
endmodule

// File: rtl/wbc_return_mux.sv
// Wishbone classic fan-out / return mux: one master to NS slaves.
//   clk, rst : clock, asynchronous active-high reset
//   sel_i    : slave index from the address decoder (all-ones or >= NS = no hit)
//   bus      : master and slave signals (see wbc_return_mux_if)
// The slave index is latched when a cycle starts and held until m_cyc_i drops.
// Unmapped indices and silent slaves are answered with m_err_o so the master
// never stalls forever.
module wbc_return_mux
  import wbc_pkg::*;
#(
  parameter int NS        = 8,
  parameter int SELWIDTH  = 4,
  parameter int ADDRWIDTH = 32,
  parameter int DATAWIDTH = 32,
  parameter int TIMEOUT   = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SELWIDTH-1:0] sel_i,
  wbc_return_mux_if.slave     bus
);
  localparam int IW_RAW = wbc_clog2(NS);
  localparam int IW     = (IW_RAW < 1) ? 1 : IW_RAW;

  wbc_state_t     state_reg, state_next;
  logic [IW-1:0]  cur_reg, cur_next;
  logic           err_q_reg, err_q_next;

  logic                 hit;
  logic                 busy;
  logic                 sel_ack;
  logic                 sel_err;
  logic                 expired;
  logic [DATAWIDTH-1:0] s_dat_arr [NS];

  assign hit  = (sel_i != WBC_NOHIT[SELWIDTH-1:0]) && (32'(sel_i) < 32'(NS));
  assign busy = (state_reg == BUSY);

  // Write-side signals are broadcast; only the strobed slave acts on them.
  assign bus.s_we_o  = bus.m_we_i;
  assign bus.s_sel_o = bus.m_sel_i;
  assign bus.s_adr_o = bus.m_adr_i;
  assign bus.s_dat_o = bus.m_dat_i;

  generate
    for (genvar gi = 0; gi < NS; gi++) begin : g_slave
      assign s_dat_arr[gi]   = bus.s_dat_i[gi*DATAWIDTH +: DATAWIDTH];
      assign bus.s_cyc_o[gi] = busy && (cur_reg == IW'(gi)) && bus.m_cyc_i;
      assign bus.s_stb_o[gi] = busy && (cur_reg == IW'(gi)) && bus.m_stb_i;
    end
  endgenerate

  assign sel_ack = bus.s_ack_i[cur_reg];
  assign sel_err = bus.s_err_i[cur_reg];

  wbc_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .en      (busy && bus.m_stb_i),
    .clear   (!busy || !bus.m_stb_i || sel_ack || sel_err),
    .expired (expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      cur_reg   <= '0;
      err_q_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cur_reg   <= cur_next;
      err_q_reg <= err_q_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    cur_next    = cur_reg;
    err_q_next  = err_q_reg;
    bus.m_ack_o = 1'b0;
    bus.m_err_o = 1'b0;
    bus.m_dat_o = '0;
    case (state_reg)
      IDLE: begin
        err_q_next = 1'b0;
        if (bus.m_cyc_i && bus.m_stb_i) begin
          cur_next = sel_i[IW-1:0];
          if (hit) begin
            state_next = BUSY;
          end else begin
            state_next = FAULT;
            err_q_next = 1'b1;
          end
        end
      end
      BUSY: begin
        // Gated by cyc so a response arriving after the master quits is dropped.
        bus.m_ack_o = sel_ack && bus.m_cyc_i;
        bus.m_err_o = sel_err && bus.m_cyc_i;
        bus.m_dat_o = s_dat_arr[cur_reg];
        if (!bus.m_cyc_i) begin
          state_next = IDLE;
        end else if (expired && !sel_ack && !sel_err) begin
          state_next = FAULT;
          err_q_next = 1'b1;
        end
      end
      FAULT: begin
        bus.m_err_o = err_q_reg;
        // Toggle so a held strobe sees one error per handshake.
        err_q_next  = bus.m_stb_i && !err_q_reg;
        if (!bus.m_cyc_i) begin
          state_next = IDLE;
          err_q_next = 1'b0;
        end
      end
      default: begin
        state_next = IDLE;
        err_q_next = 1'b0;
      end
    endcase
  end
endmodule

// File: tb/tb_wbc_return_mux.sv
module tb_wbc_return_mux;
  import wbc_pkg::*;

  logic       clk;
  logic       rst;
  logic [3:0] sel_i;
  int         tests_run;
  int         tests_failed;
  int         acks;

  wbc_return_mux_if #(.NS(8), .ADDRWIDTH(32), .DATAWIDTH(32)) bus ();

  wbc_return_mux #(
    .NS(8), .SELWIDTH(4), .ADDRWIDTH(32), .DATAWIDTH(32), .TIMEOUT(4)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .sel_i (sel_i),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time expired, want $finish earlier");
    $fatal(1);
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    bus.m_cyc_i = 1'b0;
    bus.m_stb_i = 1'b0;
    bus.m_we_i  = 1'b0;
    bus.m_sel_i = 4'hF;
    bus.m_adr_i = 32'h0;
    bus.m_dat_i = 32'h0;
    bus.s_ack_i = 8'h00;
    bus.s_err_i = 8'h00;
    // Distinct background data per slave so a wrong mux leg is visible.
    for (int k = 0; k < 8; k++) bus.s_dat_i[k*32 +: 32] = 32'hA0A0_0000 | k;
  endtask

  task automatic start(input logic [3:0] idx, input logic we);
    sel_i       = idx;
    bus.m_cyc_i = 1'b1;
    bus.m_stb_i = 1'b1;
    bus.m_we_i  = we;
    bus.m_adr_i = {24'h0, idx, 4'h0};
  endtask

  task automatic test_reset();
    rst = 1'b1;
    sel_i = 4'h0;
    bus_idle();
    @(negedge clk);
    tests_run++;
    if ({bus.s_cyc_o, bus.s_stb_o, bus.m_ack_o, bus.m_err_o} !== 18'h0 || bus.m_dat_o !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_outputs: cyc=%h stb=%h ack=%b err=%b dat=%h, want all 0",
               bus.s_cyc_o, bus.s_stb_o, bus.m_ack_o, bus.m_err_o, bus.m_dat_o);
    end
    rst = 1'b0;
    next_cycle();
  endtask

  task automatic test_read();
    start(4'd2, 1'b0);
    @(negedge clk);
    tests_run++;
    if (bus.s_stb_o !== 8'h00) begin
      tests_failed++; $display("FAIL rd_first_stb: got %h want 00", bus.s_stb_o);
    end
    next_cycle();
    bus.s_ack_i = 8'h08;  // rogue ack from an unselected slave
    @(negedge clk);
    tests_run++;
    if (bus.s_stb_o !== 8'h04 || bus.s_cyc_o !== 8'h04 || bus.m_ack_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL rd_route: stb=%h cyc=%h ack=%b want 04 04 0", bus.s_stb_o, bus.s_cyc_o, bus.m_ack_o);
    end
    next_cycle();
    bus.s_ack_i = 8'h04;
    bus.s_dat_i[2*32 +: 32] = 32'hDEAD_BEEF;
    @(negedge clk);
    tests_run++;
    if (bus.m_ack_o !== 1'b1 || bus.m_err_o !== 1'b0 || bus.m_dat_o !== 32'hDEAD_BEEF || bus.s_stb_o !== 8'h04) begin
      tests_failed++;
      $display("FAIL rd_ack: ack=%b err=%b dat=%h stb=%h want 1 0 deadbeef 04",
               bus.m_ack_o, bus.m_err_o, bus.m_dat_o, bus.s_stb_o);
    end
    next_cycle();
    bus_idle();
    @(negedge clk);
    tests_run++;
    if (bus.s_cyc_o !== 8'h00 || bus.m_ack_o !== 1'b0) begin
      tests_failed++; $display("FAIL rd_end: cyc=%h ack=%b want 00 0", bus.s_cyc_o, bus.m_ack_o);
    end
    next_cycle();
  endtask

  task automatic test_unmapped();
    start(4'hF, 1'b0);
    @(negedge clk);
    tests_run++;
    if (bus.m_err_o !== 1'b0 || bus.s_cyc_o !== 8'h00) begin
      tests_failed++; $display("FAIL um_first: err=%b cyc=%h want 0 00", bus.m_err_o, bus.s_cyc_o);
    end
    next_cycle();
    @(negedge clk);
    tests_run++;
    if (bus.m_err_o !== 1'b1 || bus.m_ack_o !== 1'b0 || bus.s_cyc_o !== 8'h00 || bus.m_dat_o !== 32'h0) begin
      tests_failed++;
      $display("FAIL um_err: err=%b ack=%b cyc=%h dat=%h want 1 0 00 0",
               bus.m_err_o, bus.m_ack_o, bus.s_cyc_o, bus.m_dat_o);
    end
    next_cycle();
    bus_idle();
    @(negedge clk);
    tests_run++;
    if (bus.m_err_o !== 1'b0) begin
      tests_failed++; $display("FAIL um_single: err=%b want 0", bus.m_err_o);
    end
    // If the mux went back to IDLE, a fresh access to slave 0 routes normally.
    next_cycle();
    start(4'd0, 1'b0);
    next_cycle();
    @(negedge clk);
    tests_run++;
    if (bus.s_stb_o !== 8'h01 || bus.m_err_o !== 1'b0) begin
      tests_failed++; $display("FAIL um_recover: stb=%h err=%b want 01 0", bus.s_stb_o, bus.m_err_o);
    end
    next_cycle();
    bus_idle();
    next_cycle();
  endtask

  task automatic test_timeout();
    start(4'd5, 1'b0);
    for (int c = 0; c < 4; c++) begin
      next_cycle();
      @(negedge clk);
      tests_run++;
      if (bus.s_stb_o !== 8'h20 || bus.m_err_o !== 1'b0) begin
        tests_failed++;
        $display("FAIL to_wait%0d: stb=%h err=%b want 20 0", c, bus.s_stb_o, bus.m_err_o);
      end
    end
    next_cycle();
    @(negedge clk);
    tests_run++;
    if (bus.s_cyc_o !== 8'h00 || bus.m_err_o !== 1'b1 || bus.m_ack_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL to_fault: cyc=%h err=%b ack=%b want 00 1 0", bus.s_cyc_o, bus.m_err_o, bus.m_ack_o);
    end
    next_cycle();
    bus_idle();
    @(negedge clk);
    tests_run++;
    if (bus.m_err_o !== 1'b0) begin
      tests_failed++; $display("FAIL to_pulse: err=%b want 0", bus.m_err_o);
    end
    next_cycle();
    // Same slave, but it answers on the last allowed cycle: ack beats the timeout.
    start(4'd5, 1'b0);
    for (int c = 0; c < 3; c++) next_cycle();
    next_cycle();
    bus.s_ack_i = 8'h20;
    @(negedge clk);
    tests_run++;
    if (bus.m_ack_o !== 1'b1 || bus.m_err_o !== 1'b0) begin
      tests_failed++; $display("FAIL to_late_ack: ack=%b err=%b want 1 0", bus.m_ack_o, bus.m_err_o);
    end
    next_cycle();
    bus_idle();
    @(negedge clk);
    tests_run++;
    if (bus.m_err_o !== 1'b0 || bus.s_cyc_o !== 8'h00) begin
      tests_failed++; $display("FAIL to_no_fault: err=%b cyc=%h want 0 00", bus.m_err_o, bus.s_cyc_o);
    end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    logic [31:0] wdat [3];
    logic [4:0]  acked;
    wdat[0] = 32'h1111_0001;
    wdat[1] = 32'h2222_0002;
    wdat[2] = 32'h3333_0003;
    acks = 0;
    start(4'd1, 1'b1);
    bus.m_dat_i = wdat[0];
    next_cycle();
    // Pattern over five BUSY cycles: ack, wait, ack, ack, plus final drop.
    acked = 5'b01101;
    for (int c = 0; c < 4; c++) begin
      sel_i = 4'd3;
      bus.s_ack_i = acked[c] ? 8'h02 : 8'h00;
      if (c == 2) bus.m_dat_i = wdat[1];
      if (c == 3) bus.m_dat_i = wdat[2];
      @(negedge clk);
      if (bus.m_ack_o === 1'b1) acks++;
      tests_run++;
      if (bus.s_stb_o !== 8'h02 || bus.s_we_o !== 1'b1 || bus.s_dat_o !== bus.m_dat_i) begin
        tests_failed++;
        $display("FAIL blk_route%0d: stb=%h we=%b sdat=%h want 02 1 %h",
                 c, bus.s_stb_o, bus.s_we_o, bus.s_dat_o, bus.m_dat_i);
      end
      next_cycle();
    end
    bus_idle();
    @(negedge clk);
    tests_run++;
    if (acks != 3 || bus.s_cyc_o !== 8'h00) begin
      tests_failed++; $display("FAIL blk_acks: acks=%0d cyc=%h want 3 00", acks, bus.s_cyc_o);
    end
    next_cycle();
  endtask

  task automatic test_async_reset();
    start(4'd6, 1'b0);
    next_cycle();
    bus.s_ack_i = 8'h40;
    #1;
    tests_run++;
    if (bus.s_cyc_o !== 8'h40 || bus.m_ack_o !== 1'b1) begin
      tests_failed++; $display("FAIL ar_pre: cyc=%h ack=%b want 40 1", bus.s_cyc_o, bus.m_ack_o);
    end
    rst = 1'b1;
    #1;
    tests_run++;
    if (bus.s_cyc_o !== 8'h00 || bus.m_ack_o !== 1'b0 || bus.m_err_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL ar_now: cyc=%h ack=%b err=%b want 00 0 0", bus.s_cyc_o, bus.m_ack_o, bus.m_err_o);
    end
    bus_idle();
    @(negedge clk);
    rst = 1'b0;
    next_cycle();
    start(4'd0, 1'b0);
    next_cycle();
    bus.s_ack_i = 8'h01;
    bus.s_dat_i[0 +: 32] = 32'h1234_5678;
    @(negedge clk);
    tests_run++;
    if (bus.s_stb_o !== 8'h01 || bus.m_ack_o !== 1'b1 || bus.m_dat_o !== 32'h1234_5678) begin
      tests_failed++;
      $display("FAIL ar_after: stb=%h ack=%b dat=%h want 01 1 12345678", bus.s_stb_o, bus.m_ack_o, bus.m_dat_o);
    end
    next_cycle();
    bus_idle();
    next_cycle();
  endtask

  task automatic test_abandon();
    start(4'd4, 1'b0);
    next_cycle();
    next_cycle();
    bus_idle();
    @(negedge clk);
    tests_run++;
    if (bus.s_cyc_o !== 8'h00 || bus.m_ack_o !== 1'b0) begin
      tests_failed++; $display("FAIL ab_drop: cyc=%h ack=%b want 00 0", bus.s_cyc_o, bus.m_ack_o);
    end
    next_cycle();
    bus.s_ack_i = 8'h10;  // late ack after the master gave up
    @(negedge clk);
    tests_run++;
    if (bus.m_ack_o !== 1'b0 || bus.s_cyc_o !== 8'h00) begin
      tests_failed++; $display("FAIL ab_late: ack=%b cyc=%h want 0 00", bus.m_ack_o, bus.s_cyc_o);
    end
    next_cycle();
    bus.s_ack_i = 8'h00;
    start(4'd4, 1'b0);
    next_cycle();
    @(negedge clk);
    tests_run++;
    if (bus.s_stb_o !== 8'h10 || bus.m_ack_o !== 1'b0) begin
      tests_failed++; $display("FAIL ab_next: stb=%h ack=%b want 10 0", bus.s_stb_o, bus.m_ack_o);
    end
    next_cycle();
    bus.s_ack_i = 8'h10;
    bus.s_dat_i[4*32 +: 32] = 32'h0BAD_F00D;
    @(negedge clk);
    tests_run++;
    if (bus.m_ack_o !== 1'b1 || bus.m_dat_o !== 32'h0BAD_F00D) begin
      tests_failed++; $display("FAIL ab_next_ack: ack=%b dat=%h want 1 0badf00d", bus.m_ack_o, bus.m_dat_o);
    end
    next_cycle();
    bus_idle();
    next_cycle();
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_read();
    test_unmapped();
    test_timeout();
    test_back_to_back();
    test_async_reset();
    test_abandon();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
